// File: rtl/mem_bus_responder.sv
// Main-memory responder on the snooping bus: timed line fills (abortable by a snooper) and write-backs.
// Optional protocol checker enabled by defining MEM_PROTO_CHECK_EN; otherwise Proto_err is tied low.
module mem_bus_responder #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned RESP_DELAY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address_Com,
    input  logic [DATA_WIDTH-1:0] Data_Bus_Com_in,
    output logic [DATA_WIDTH-1:0] Data_Bus_Com_out,
    output logic                  Data_Bus_Com_oe,
    input  logic                  BusRd,
    input  logic                  BusRdX,
    input  logic                  Mem_wr,
    input  logic                  Mem_oprn_abort,
    output logic                  Data_in_Bus,
    output logic                  Mem_write_done,
    output logic                  Mem_busy,
    output logic                  Proto_err
);

    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CW    = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESP_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        RD_DRAIN,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic                    rd_req;
    logic                    mem_we;
    logic                    rd_resp;

    assign rd_req = BusRd | BusRdX;
    assign idx    = addr_q[MEM_DEPTH_LOG2+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // Write-back wins so a victim lands before its replacement fill.
                if (Mem_wr) begin
                    addr_d  = Address_Com;
                    wdata_d = Data_Bus_Com_in;
                    cnt_d   = CNT_LOAD;
                    state_d = WR_WAIT;
                end else if (rd_req) begin
                    addr_d  = Address_Com;
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (Mem_oprn_abort)     state_d = RD_DRAIN;
                else if (cnt_q == '0)   state_d = RD_RESP;
                else                    cnt_d   = cnt_q - CW'(1);
            end
            RD_RESP, RD_DRAIN: begin
                if (!rd_req) state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = 1'b1;
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_DONE: begin
                if (!Mem_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_resp          = (state_q == RD_RESP);
        Data_in_Bus      = rd_resp;
        Data_Bus_Com_oe  = rd_resp;
        Data_Bus_Com_out = rd_resp ? mem[idx] : '0;
        Mem_write_done   = (state_q == WR_DONE);
        Mem_busy         = (state_q != IDLE);
    end

    // Storage is not reset; a reset coinciding with the commit edge discards the write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[idx] <= wdata_q;
    end

`ifdef MEM_PROTO_CHECK_EN
    logic perr_q, perr_d;
    logic in_rd, in_wr, addr_held, violation;

    always_comb begin
        in_rd     = (state_q == RD_WAIT) || (state_q == RD_RESP) || (state_q == RD_DRAIN);
        in_wr     = (state_q == WR_WAIT) || (state_q == WR_DONE);
        addr_held = (state_q == RD_WAIT) || (state_q == RD_RESP) || in_wr;
        violation = (BusRd && BusRdX)
                  || (in_rd && Mem_wr)
                  || (in_wr && rd_req)
                  || (addr_held && (Address_Com != addr_q))
                  || ((state_q == IDLE) && Mem_oprn_abort);
        perr_d    = perr_q | violation;
    end

    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign Proto_err = perr_q;
`else
    logic unused_addr;
    assign unused_addr = ^addr_q;
    assign Proto_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios plus randomized traffic vs. a word-array model.
module tb_mem_bus_responder;

    localparam int D = 4;
`ifdef MEM_PROTO_CHECK_EN
    localparam bit PROTO_EN = 1'b1;
`else
    localparam bit PROTO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address_Com;
    logic [31:0] Data_Bus_Com_in;
    logic [31:0] Data_Bus_Com_out;
    logic        Data_Bus_Com_oe;
    logic        BusRd, BusRdX, Mem_wr, Mem_oprn_abort;
    logic        Data_in_Bus, Mem_write_done, Mem_busy, Proto_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [int];
    int written [$];

    always #5 clk = ~clk;

    mem_bus_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH_LOG2(10),
        .RESP_DELAY(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Address_Com(Address_Com),
        .Data_Bus_Com_in(Data_Bus_Com_in),
        .Data_Bus_Com_out(Data_Bus_Com_out),
        .Data_Bus_Com_oe(Data_Bus_Com_oe),
        .BusRd(BusRd),
        .BusRdX(BusRdX),
        .Mem_wr(Mem_wr),
        .Mem_oprn_abort(Mem_oprn_abort),
        .Data_in_Bus(Data_in_Bus),
        .Mem_write_done(Mem_write_done),
        .Mem_busy(Mem_busy),
        .Proto_err(Proto_err)
    );

    // 1024-word array: index is the word address modulo the depth.
    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd1024);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; BusRd = 1'b0; BusRdX = 1'b0; Mem_wr = 1'b0; Mem_oprn_abort = 1'b0;
        Address_Com = '0; Data_Bus_Com_in = '0;
        tick(); tick();
        total++; if (Data_in_Bus !== 1'b0)      begin bad++; $display("FAIL rst_din: got %b want 0", Data_in_Bus); end
        total++; if (Data_Bus_Com_oe !== 1'b0)  begin bad++; $display("FAIL rst_oe: got %b want 0", Data_Bus_Com_oe); end
        total++; if (Mem_write_done !== 1'b0)   begin bad++; $display("FAIL rst_wdone: got %b want 0", Mem_write_done); end
        total++; if (Mem_busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b want 0", Mem_busy); end
        total++; if (Proto_err !== 1'b0)        begin bad++; $display("FAIL rst_perr: got %b want 0", Proto_err); end
        total++; if (Data_Bus_Com_out !== 32'h0) begin bad++; $display("FAIL rst_dout: got %h want 0", Data_Bus_Com_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_back(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address_Com = addr; Data_Bus_Com_in = data; Mem_wr = 1'b1;
        tick();
        total++; if (Mem_busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", Mem_busy); end
        @(negedge clk);
        Data_Bus_Com_in = $urandom;
        for (int k = 1; k <= D; k++) begin
            tick();
            total++;
            if (Mem_write_done !== (k == D)) begin
                bad++; $display("FAIL wr_done_lat edge %0d: got %b want %b", k, Mem_write_done, (k == D));
            end
        end
        model[widx(addr)] = data;
        if (!(widx(addr) inside {written})) written.push_back(widx(addr));
        tick();
        total++; if (Mem_write_done !== 1'b1) begin bad++; $display("FAIL wr_done_hold: got %b want 1", Mem_write_done); end
        @(negedge clk);
        Mem_wr = 1'b0;
        tick();
        total++; if (Mem_busy !== 1'b0 || Mem_write_done !== 1'b0) begin
            bad++; $display("FAIL wr_idle: busy=%b done=%b want 0/0", Mem_busy, Mem_write_done);
        end
    endtask

    // abort_at = 0: no abort; otherwise abort is high at the abort_at-th edge after the request sample.
    task automatic test_read(input logic [31:0] addr, input bit rdx, input int abort_at);
        logic [31:0] exp;
        exp = (abort_at == 0) ? model[widx(addr)] : 32'h0;
        @(negedge clk);
        Address_Com = addr; BusRd = !rdx; BusRdX = rdx;
        tick();
        total++; if (Mem_busy !== 1'b1) begin bad++; $display("FAIL rd_busy: got %b want 1", Mem_busy); end
        for (int k = 1; k <= D; k++) begin
            @(negedge clk);
            Mem_oprn_abort = (k == abort_at);
            tick();
            total++;
            if (abort_at != 0 || k < D) begin
                if (Data_in_Bus !== 1'b0 || Data_Bus_Com_oe !== 1'b0 || Data_Bus_Com_out !== 32'h0) begin
                    bad++; $display("FAIL rd_wait edge %0d: din=%b oe=%b dout=%h want 0/0/0",
                                    k, Data_in_Bus, Data_Bus_Com_oe, Data_Bus_Com_out);
                end
            end else begin
                if (Data_in_Bus !== 1'b1 || Data_Bus_Com_oe !== 1'b1 || Data_Bus_Com_out !== exp) begin
                    bad++; $display("FAIL rd_resp: din=%b oe=%b dout=%h want 1/1/%h",
                                    Data_in_Bus, Data_Bus_Com_oe, Data_Bus_Com_out, exp);
                end
            end
        end
        @(negedge clk);
        Mem_oprn_abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (abort_at != 0) begin
                if (Data_in_Bus !== 1'b0 || Data_Bus_Com_oe !== 1'b0 || Mem_busy !== 1'b1) begin
                    bad++; $display("FAIL rd_drain: din=%b oe=%b busy=%b want 0/0/1",
                                    Data_in_Bus, Data_Bus_Com_oe, Mem_busy);
                end
            end else if (Data_in_Bus !== 1'b1 || Data_Bus_Com_out !== exp) begin
                bad++; $display("FAIL rd_hold: din=%b dout=%h want 1/%h", Data_in_Bus, Data_Bus_Com_out, exp);
            end
        end
        @(negedge clk);
        BusRd = 1'b0; BusRdX = 1'b0;
        tick();
        total++;
        if (Mem_busy !== 1'b0 || Data_in_Bus !== 1'b0 || Data_Bus_Com_oe !== 1'b0 || Data_Bus_Com_out !== 32'h0) begin
            bad++; $display("FAIL rd_idle: busy=%b din=%b oe=%b dout=%h want all 0",
                            Mem_busy, Data_in_Bus, Data_Bus_Com_oe, Data_Bus_Com_out);
        end
    endtask

    task automatic test_priority();
        logic [31:0] a;
        a = 32'h0001_0004;
        @(negedge clk);
        Address_Com = a; Data_Bus_Com_in = 32'hbeadbead; Mem_wr = 1'b1; BusRd = 1'b1;
        tick();
        for (int k = 1; k <= D; k++) begin
            tick();
            total++;
            if (Mem_write_done !== (k == D) || Data_in_Bus !== 1'b0) begin
                bad++; $display("FAIL prio_wr edge %0d: done=%b din=%b want %b/0", k, Mem_write_done, Data_in_Bus, (k == D));
            end
        end
        model[widx(a)] = 32'hbeadbead;
        @(negedge clk);
        Mem_wr = 1'b0;
        tick();
        total++; if (Mem_busy !== 1'b0) begin bad++; $display("FAIL prio_idle: busy=%b want 0", Mem_busy); end
        for (int j = 1; j <= D + 1; j++) begin
            tick();
            total++;
            if (Data_in_Bus !== (j == D + 1)) begin
                bad++; $display("FAIL prio_rd_lat edge %0d: din=%b want %b", j, Data_in_Bus, (j == D + 1));
            end
        end
        total++;
        if (Data_Bus_Com_out !== model[1]) begin
            bad++; $display("FAIL prio_rd_data: got %h want %h", Data_Bus_Com_out, model[1]);
        end
        @(negedge clk);
        BusRd = 1'b0;
        tick();
        total++; if (Mem_busy !== 1'b0 || Data_in_Bus !== 1'b0) begin
            bad++; $display("FAIL prio_end: busy=%b din=%b want 0/0", Mem_busy, Data_in_Bus);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        Address_Com = 32'h4; Data_Bus_Com_in = 32'h1234_5678; Mem_wr = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        rst = 1'b1; Mem_wr = 1'b0;
        tick();
        total++;
        if (Mem_busy !== 1'b0 || Mem_write_done !== 1'b0 || Data_in_Bus !== 1'b0 || Data_Bus_Com_oe !== 1'b0) begin
            bad++; $display("FAIL rstmid_out: busy=%b done=%b din=%b oe=%b want all 0",
                            Mem_busy, Mem_write_done, Data_in_Bus, Data_Bus_Com_oe);
        end
        @(negedge clk);
        rst = 1'b0;
        test_read(32'h4, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            int ab;
            if (written.size() == 0 || $urandom_range(0, 2) == 0) begin
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 1023)) << 2);
                test_write_back(a, $urandom);
            end else begin
                a = ($urandom & 32'hFFFF_F000) | (32'(written[$urandom_range(0, written.size() - 1)]) << 2);
                ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D)) : 0;
                test_read(a, 1'($urandom_range(0, 1)), ab);
            end
        end
    endtask

    task automatic test_proto();
        test_reset();
        @(negedge clk);
        Address_Com = 32'h10; BusRd = 1'b1; BusRdX = 1'b1;
        tick();
        total++; if (Proto_err !== PROTO_EN) begin bad++; $display("FAIL proto_set: got %b want %b", Proto_err, PROTO_EN); end
        @(negedge clk);
        BusRd = 1'b0; BusRdX = 1'b0;
        for (int k = 0; k < D + 3; k++) tick();
        total++; if (Proto_err !== PROTO_EN) begin bad++; $display("FAIL proto_sticky: got %b want %b", Proto_err, PROTO_EN); end
        total++; if (Mem_busy !== 1'b0) begin bad++; $display("FAIL proto_idle: busy=%b want 0", Mem_busy); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++; if (Proto_err !== 1'b0) begin bad++; $display("FAIL proto_clr: got %b want 0", Proto_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_back(32'h0000_0004, 32'hcafecafb);
        test_read(32'h0000_0004, 1'b0, 0);
        test_write_back(32'h0000_0008, 32'h0bad_f00d);
        test_read(32'h0000_0008, 1'b1, 2);
        test_read(32'h0000_0008, 1'b1, D);
        test_read(32'h0000_0008, 1'b1, 0);
        test_priority();
        test_write_back(32'h0000_0004, 32'hcafecafb);
        test_reset_mid_write();
        test_random();
        test_proto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
